// File: rtl/sdiv_pkg.sv
// Shared types and constants for the signed/unsigned divide front-end.
// Holds the controller state encoding, default width and watchdog limit formula.
package sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam int SDIV_N = 16;

    function automatic int sdiv_timeout(input int n);
        return 4 * n + 8;
    endfunction

    // Most negative two's-complement value for an n-bit operand.
    function automatic logic [63:0] sdiv_smin(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/sdiv_sign_fix.sv
// Restores the sign of the unsigned divider results for signed operations.
// Quotient follows sign(a)^sign(b); remainder follows the dividend's sign.
module sdiv_sign_fix
    import sdiv_pkg::*;
#(
    parameter int N = SDIV_N
) (
    input  logic         a_neg,
    input  logic         b_neg,
    input  logic         op_signed,
    input  logic [N-1:0] div_q,
    input  logic [N-1:0] div_r,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem
);

    logic q_flip;
    logic r_flip;

    assign q_flip = op_signed & (a_neg ^ b_neg);
    assign r_flip = op_signed & a_neg;

    assign quo = q_flip ? -div_q : div_q;
    assign rem = r_flip ? -div_r : div_r;

endmodule

// File: rtl/sdiv_ctrl.sv
// Divide front-end: handshakes one operation at a time, resolves x/0 and MIN/-1 locally,
// drives operand magnitudes to the iterative divider and sign-corrects its answer.
module sdiv_ctrl
    import sdiv_pkg::*;
#(
    parameter int N       = SDIV_N,
    parameter int TIMEOUT = sdiv_timeout(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op_signed,
    input  logic         op_rem,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         timeout,
    output logic         div_req,
    output logic [N-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic [N-1:0] div_q,
    input  logic [N-1:0] div_r,
    input  logic         div_ready,
    input  logic         div_exception
);

    localparam logic [N-1:0] SMIN = N'(sdiv_smin(N));

    state_t       state;
    state_t       state_nx;
    logic         a_neg_q;
    logic         b_neg_q;
    logic         signed_q;
    logic         rem_q;
    logic [15:0]  wdog;
    logic [15:0]  wdog_inc;
    logic         wdog_expired;
    logic         is_zero;
    logic         is_ovf;
    logic [N-1:0] fix_q;
    logic [N-1:0] fix_r;

    assign is_zero      = (b == '0);
    assign is_ovf       = op_signed && (a == SMIN) && (b == '1);
    assign wdog_inc     = wdog + 16'd1;
    assign wdog_expired = (wdog_inc == 16'(TIMEOUT));

    // Handshake/request outputs decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign div_req   = (state == ISSUE);

    sdiv_sign_fix #(.N(N)) u_sign_fix (
        .a_neg     (a_neg_q),
        .b_neg     (b_neg_q),
        .op_signed (signed_q),
        .div_q     (div_q),
        .div_r     (div_r),
        .quo       (fix_q),
        .rem       (fix_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = (is_zero || is_ovf) ? DONE : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (div_ready || wdog_expired) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Divider responses take priority over the watchdog when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_neg_q      <= 1'b0;
            b_neg_q      <= 1'b0;
            signed_q     <= 1'b0;
            rem_q        <= 1'b0;
            result       <= '0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wdog         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_neg_q  <= a[N-1];
                        b_neg_q  <= b[N-1];
                        signed_q <= op_signed;
                        rem_q    <= op_rem;
                        if (is_zero) begin
                            result      <= op_rem ? a : '1;
                            div_by_zero <= 1'b1;
                        end else if (is_ovf) begin
                            result   <= op_rem ? '0 : SMIN;
                            overflow <= 1'b1;
                        end else begin
                            div_dividend <= (op_signed && a[N-1]) ? -a : a;
                            div_divisor  <= (op_signed && b[N-1]) ? -b : b;
                        end
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                end
                WAIT: begin
                    wdog <= wdog_inc;
                    if (div_ready) begin
                        if (div_exception) begin
                            result      <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            result <= rem_q ? fix_r : fix_q;
                        end
                    end else if (wdog_expired) begin
                        result  <= '0;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sdiv_ctrl.md
# sdiv_ctrl

Signed/unsigned divide front-end between the CPU execute stage and the iterative unsigned `divider` (`req`/`ready`/`exception` protocol).
- Accepts one divide operation per valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally.
- Feeds operand magnitudes to the divider and sign-corrects the returned quotient/remainder.
- Holds the result until the consumer accepts it.
- Never more than one operation in flight.

## Interface
- N, 16, operand/result width; must match the divider's N.
- TIMEOUT, 4*N+8, max cycles in WAIT before aborting; 16-bit counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept (IDLE only).
- op_signed  in  1  1 = two's-complement operands.
- op_rem  in  1  1 = return remainder, 0 = quotient.
- a  in  N  dividend.
- b  in  N  divisor.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- result  out  N  quotient or remainder.
- div_by_zero  out  1  status, valid with out_valid.
- overflow  out  1  status, valid with out_valid.
- timeout  out  1  status, valid with out_valid.
- div_req  out  1  one-cycle pulse to divider.
- div_dividend, div_divisor  out  N  magnitudes, stable from ISSUE until the response.
- div_q, div_r  in  N  divider results, sampled when div_ready=1.
- div_ready  in  1  divider done.
- div_exception  in  1  divider flagged a zero divisor.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. When in_valid=1, capture a, b, op_signed, op_rem.
  - b==0 -> DONE. result = all-ones if op_rem=0, else a; div_by_zero=1.
  - op_signed and a==2^(N-1) and b==all-ones -> DONE. result = 2^(N-1) if op_rem=0, else 0; overflow=1.
  - Otherwise -> ISSUE.
- ISSUE: div_req=1 for exactly one cycle. div_dividend=|a|, div_divisor=|b|. Magnitudes are taken only when op_signed; |2^(N-1)| = 2^(N-1) unsigned. Next state WAIT; watchdog cleared.
- WAIT: watchdog increments every cycle.
  - On div_ready=1: capture results and go to DONE.
    - If div_exception=1, set div_by_zero=1 and result = 0.
    - Otherwise: quotient is negated when op_signed and sign(a)!=sign(b). Remainder is negated when op_signed and a<0. Arithmetic is modulo 2^N.
  - If watchdog reaches TIMEOUT first: result=0, timeout=1, go to DONE.
- DONE: out_valid=1; result and all status flags are held stable. When out_ready=1, go to IDLE and clear out_valid and the flags.
- div_ready/div_exception are ignored outside WAIT.
- in_valid is ignored outside IDLE.
- Reset (any state, including WAIT) -> IDLE. The divider has its own reset; a stale div_ready after reset is ignored because the block is not in WAIT.

## Timing
- Reset values: in_ready=1; out_valid=0, result=0, div_by_zero=0, overflow=0, timeout=0, div_req=0; div_dividend=0, div_divisor=0.
- Special cases: accepted at edge T -> out_valid at T+1.
- Normal path: accepted at T -> div_req high during cycle T+1. If div_ready is first sampled high at edge D, out_valid is high from D+1.
- out_valid stays high until the edge where out_ready=1. The next in_ready is high one cycle later, so there is no same-cycle turnaround.
- All outputs are registered; there is no combinational path from in_valid or out_ready to any output.

## Structure
- Package sdiv_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the default N and the TIMEOUT formula;
  - the local constant for the signed minimum.
- One sub-module, sdiv_sign_fix (combinational). Inputs: captured a/b signs, op_signed, div_q, div_r. Outputs: corrected quotient and remainder.
- The divider is instantiated by the parent, not inside this block.

## Test plan
- Unsigned 100/7, op_rem=0 then op_rem=1 -> result 14 (0x000E), then 2. Exactly one div_req per operation.
- Signed 0xFFF9 / 0x0002 (-7/2) -> div_divisor=2, div_dividend=7. Quotient 0xFFFD (-3); remainder 0xFFFF (-1).
- b=0, a=0x1234 -> no div_req. out_valid one cycle after accept. Result 0xFFFF (quotient) or 0x1234 (remainder); div_by_zero=1.
- Signed 0x8000 / 0xFFFF -> no div_req. Quotient 0x8000, overflow=1. Unsigned 0x8000 / 0xFFFF goes to the divider and gives quotient 0.
- Divider stub never raises div_ready -> out_valid exactly TIMEOUT+1 cycles after the div_req cycle, with timeout=1 and result=0.
- Back-pressure: hold out_ready=0 for 5 cycles -> result/flags stable and in_ready=0. Assert rst during WAIT -> all outputs at reset values and the following operation completes correctly.
